// File: rtl/rr_mux_scheduler.sv
// ----------------------------------------------------------------------------
// rr_mux_scheduler
// Round-robin scheduler for a shared 4-to-1, W-bit select datapath.
// Four requesters (u, v, w, x) compete for one output path. The winner holds
// the path for at most HOLD_CYCLES cycles, or less if it releases early.
// The select, the one-hot grant and the muxed data are all registered.
// ----------------------------------------------------------------------------
module rr_mux_scheduler #(
    parameter int W           = 2,
    parameter int HOLD_CYCLES = 4   // legal range 1..255
) (
    input  logic             clk,
    input  logic             reset,     // synchronous, active-high
    input  logic [3:0]       req,       // bit 0 = u, 1 = v, 2 = w, 3 = x
    input  logic [4*W-1:0]   data_in,   // {x, w, v, u}
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [W-1:0]     data_out,
    output logic             valid,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Value loaded into the hold counter when a grant starts. The grant ends
    // at the edge where the counter reads 0, so a grant with its request held
    // stays visible for exactly HOLD_CYCLES cycles.
    localparam logic [7:0] LP_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [7:0]      r_cnt;
    logic [1:0]      r_sel;
    logic [3:0]      r_grant;
    logic [W-1:0]    r_data;
    logic            r_valid;

    logic [1:0]      w_scan_ptr;
    logic [1:0]      w_winner;
    logic            w_found;
    logic            w_grant_end;
    logic [W-1:0]    w_winner_data;
    logic [W-1:0]    w_held_data;

    // While a grant is ending, the pointer update (sel + 1) takes effect at
    // this same edge, so arbitration must already scan from the new start.
    // In IDLE the stored pointer is authoritative.
    assign w_scan_ptr  = (r_state == GRANT) ? (r_sel + 2'd1) : r_ptr;

    // The current holder gives up the path when it drops its request or
    // its hold budget is used up.
    assign w_grant_end = (r_state == GRANT) && (!req[r_sel] || (r_cnt == 8'd0));

    // Cyclic priority scan: first set request at or after w_scan_ptr wins.
    always_comb begin
        logic [1:0] v_idx;
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves it unassigned, which would infer a latch.
        w_found  = 1'b0;
        w_winner = w_scan_ptr;
        for (int i = 0; i < 4; i++) begin
            v_idx = w_scan_ptr + 2'(i);
            if (!w_found && req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    assign w_winner_data = data_in[int'(w_winner) * W +: W];
    assign w_held_data   = data_in[int'(r_sel) * W +: W];

    // Scheduler FSM with registered select, grant, data and valid.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // in this block samples the pre-edge values of the others.
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= 8'd0;
            r_sel   <= 2'd0;
            r_grant <= 4'b0000;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_sel   <= w_winner;
                        r_grant <= 4'b0001 << w_winner;
                        r_data  <= w_winner_data;
                        r_cnt   <= LP_RELOAD;
                        r_valid <= 1'b1;
                    end
                end

                GRANT: begin
                    if (w_grant_end) begin
                        r_ptr <= r_sel + 2'd1;
                        if (w_found) begin
                            // Hand over without an idle bubble; the previous
                            // holder can win again if it is the only requester.
                            r_sel   <= w_winner;
                            r_grant <= 4'b0001 << w_winner;
                            r_data  <= w_winner_data;
                            r_cnt   <= LP_RELOAD;
                        end else begin
                            // Nobody is asking: sel and data keep their last values.
                            r_state <= IDLE;
                            r_grant <= 4'b0000;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt - 8'd1;
                        r_data <= w_held_data;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sel      = r_sel;
    assign grant    = r_grant;
    assign data_out = r_data;
    assign valid    = r_valid;
    assign busy     = r_valid;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_scheduler
// Directed stimulus with hand-computed expectations. The driver pushes the
// expected post-edge outputs into a queue; a monitor pops and compares them
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_rr_mux_scheduler;

    localparam int W = 2;

    // Requester data {x, w, v, u}: each requester's data equals its index.
    localparam logic [7:0] D_IDX = 8'b11_10_01_00;
    // Same as D_IDX but x carries 01 instead of 11.
    localparam logic [7:0] D_X01 = 8'b01_10_01_00;

    typedef struct {
        logic       valid;
        logic [1:0] sel;
        logic [3:0] grant;
        logic [1:0] data;
        string      name;
    } exp_t;

    logic           clk;
    logic           reset;
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [1:0]     sel;
    logic [3:0]     grant;
    logic [W-1:0]   data_out;
    logic           valid;
    logic           busy;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatch = 0;

    rr_mux_scheduler #(.W(W), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .sel      (sel),
        .grant    (grant),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and record what the outputs must be after
    // the next rising edge.
    task automatic step(input logic rst, input logic [3:0] r, input logic [7:0] d,
                        input logic ev, input logic [1:0] es, input logic [3:0] eg,
                        input logic [1:0] ed, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        reset   = rst;
        req     = r;
        data_in = d;
        e.valid = ev;
        e.sel   = es;
        e.grant = eg;
        e.data  = ed;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_compared++;
                if (valid !== e.valid || busy !== e.valid || sel !== e.sel ||
                    grant !== e.grant || data_out !== e.data) begin
                    n_mismatch++;
                    $display("FAIL %s: got valid=%b busy=%b sel=%b grant=%b data=%b, want valid=%b busy=%b sel=%b grant=%b data=%b",
                             e.name, valid, busy, sel, grant, data_out,
                             e.valid, e.valid, e.sel, e.grant, e.data);
                end
            end
        end
    end

    initial begin
        int drain;
        reset   = 1'b1;
        req     = 4'b0000;
        data_in = D_IDX;

        // Reset with all requesting.
        step(1, 4'b1111, D_IDX, 0, 2'b00, 4'b0000, 2'b00, "reset");

        // Full rotation u, v, w, x (4 cycles each), then u again.
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, 4'b1111, D_IDX, 1, 2'(g), 4'b0001 << g, 2'(g), "rotate");
            end
        end
        step(0, 4'b1111, D_IDX, 1, 2'b00, 4'b0001, 2'b00, "rotate_wrap_u");

        // Reset again; pointer back to 0.
        step(1, 4'b0000, D_IDX, 0, 2'b00, 4'b0000, 2'b00, "reset2");

        // Sole requester w re-granted back-to-back for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            step(0, 4'b0100, D_IDX, 1, 2'b10, 4'b0100, 2'b10, "sole_w");
        end
        // Drop w: idle, sel and data hold their last values.
        step(0, 4'b0000, D_IDX, 0, 2'b10, 4'b0000, 2'b10, "w_release_idle");
        step(0, 4'b0000, D_IDX, 0, 2'b10, 4'b0000, 2'b10, "idle_hold");

        // ptr = 3 now; u and v request -> u wins, releases after 2 cycles.
        step(0, 4'b0011, D_IDX, 1, 2'b00, 4'b0001, 2'b00, "u_grant_1");
        step(0, 4'b0011, D_IDX, 1, 2'b00, 4'b0001, 2'b00, "u_grant_2");
        step(0, 4'b0010, D_IDX, 1, 2'b01, 4'b0010, 2'b01, "early_release_v");
        // v started with counter 3: three more cycles even with u requesting.
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b0011, D_IDX, 1, 2'b01, 4'b0010, 2'b01, "v_hold");
        end
        step(0, 4'b0011, D_IDX, 1, 2'b00, 4'b0001, 2'b00, "v_to_u");

        // Go idle (ptr = 1), then grant x.
        step(0, 4'b0000, D_IDX, 0, 2'b00, 4'b0000, 2'b00, "u_release_idle");
        step(0, 4'b1000, D_IDX, 1, 2'b11, 4'b1000, 2'b11, "x_grant");
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b1010, D_IDX, 1, 2'b11, 4'b1000, 2'b11, "x_hold");
        end
        // x done (ptr = 0), req = 1010 -> v.
        step(0, 4'b1010, D_IDX, 1, 2'b01, 4'b0010, 2'b01, "after_x_v_wins");
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b1010, D_IDX, 1, 2'b01, 4'b0010, 2'b01, "v_hold2");
        end
        // v done (ptr = 2), req = 1010 -> x, with x data = 01.
        step(0, 4'b1010, D_X01, 1, 2'b11, 4'b1000, 2'b01, "after_v_x_wins");
        // x data changes to 11 mid-grant: seen one edge later; counter -> 2.
        step(0, 4'b1000, D_IDX, 1, 2'b11, 4'b1000, 2'b11, "data_change");

        // Reset mid-grant (sel = 11, counter = 2).
        step(1, 4'b1111, D_IDX, 0, 2'b00, 4'b0000, 2'b00, "reset_mid_grant");
        step(0, 4'b1111, D_IDX, 1, 2'b00, 4'b0001, 2'b00, "post_reset_u");
        step(0, 4'b0000, D_IDX, 0, 2'b00, 4'b0000, 2'b00, "final_idle");

        // Let the monitor drain, with a bound.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
